// File: rtl/eb1_ifu_fetch_buf.sv
// eb1_ifu_fetch_buf
// ---------------------------------------------------------------------------
// Four-entry instruction fetch buffer on the receive side of the IFU fetch
// pipe. Fetch groups (two halfwords each) are written at the write pointer.
// One 16- or 32-bit instruction per cycle is aligned out of the head of the
// buffer for decode. Entries freed by each accept are reported back to fetch
// control so that its fill model tracks the real occupancy.
//
// Optional feature macro: RV_FB_BYPASS_EN
//   When defined, an incoming group that arrives while the buffer is empty is
//   decoded combinationally and presented in its write cycle. Only the
//   halfwords left unconsumed by that cycle are stored.
//
// Ports
//   clk               core clock
//   rst_l             synchronous active-low reset
//   exu_flush_final   flush; empties the buffer, drops a same-cycle write
//   ifu_fetch_val     halfword valids of incoming group (bit0 = low half)
//   ifu_fetch_data_f  fetch group data
//   ifu_fetch_pc      PC[31:1] of the group's low halfword
//   dec_aln_ready     decode accepts the presented instruction
//   aln_valid         aln_instr / aln_pc / aln_is_16b are valid
//   aln_instr         instruction (16-bit ones zero-extended)
//   aln_pc            PC[31:1] of the presented instruction
//   aln_is_16b        presented instruction is compressed
//   ifu_fb_consume1   exactly one entry freed this cycle
//   ifu_fb_consume2   two entries freed this cycle
//   fb_overflow       sticky: a write was dropped because the buffer was full
// ---------------------------------------------------------------------------
module eb1_ifu_fetch_buf #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        exu_flush_final,
  input  logic [1:0]  ifu_fetch_val,
  input  logic [31:0] ifu_fetch_data_f,
  input  logic [30:0] ifu_fetch_pc,
  input  logic        dec_aln_ready,
  output logic        aln_valid,
  output logic [31:0] aln_instr,
  output logic [30:0] aln_pc,
  output logic        aln_is_16b,
  output logic        ifu_fb_consume1,
  output logic        ifu_fb_consume2,
  output logic        fb_overflow
);

  // Entry storage
  logic [31:0] data_r [DEPTH];
  logic [30:0] pc_r   [DEPTH];
  logic [1:0]  hv_r   [DEPTH];

  logic [1:0]  wp_r;
  logic [1:0]  rp_r;
  logic [2:0]  cnt_r;
  logic        hoff_r;
  logic        overflow_r;

  logic [1:0]  rp_nx_s;
  logic        bypass_s;
  logic        full_s;

  logic [1:0]  head_hv_s;
  logic [31:0] head_data_s;
  logic [30:0] head_pc_s;
  logic [1:0]  next_hv_s;
  logic [31:0] next_data_s;

  logic        head_present_s;
  logic        h0_hi_s;
  logic [15:0] h0_s;
  logic [15:0] h1_s;
  logic        is32_s;
  logic        h1_present_s;
  logic        h1_in_next_s;
  logic        valid_s;
  logic        accept_s;

  logic [1:0]  head_clr_s;
  logic [1:0]  next_clr_s;
  logic [1:0]  head_rem_s;
  logic [1:0]  next_rem_s;
  logic        head_free_s;
  logic        next_free_s;
  logic [1:0]  freed_s;

  logic        wr_attempt_s;
  logic        wr_en_s;
  logic [1:0]  wr_hv_s;
  logic        hoff_nx_s;

  assign rp_nx_s = rp_r + 2'd1;
  assign full_s  = (cnt_r == 3'(DEPTH));

`ifdef RV_FB_BYPASS_EN
  assign bypass_s = (cnt_r == 3'd0) & ~exu_flush_final;
`else
  assign bypass_s = 1'b0;
`endif

  // Select the head and next entry views (buffered, or the incoming group on bypass)
  always_comb begin
    head_hv_s   = 2'b00;
    head_data_s = data_r[rp_r];
    head_pc_s   = pc_r[rp_r];
    next_hv_s   = 2'b00;
    next_data_s = data_r[rp_nx_s];
    if (bypass_s) begin
      head_hv_s   = ifu_fetch_val;
      head_data_s = ifu_fetch_data_f;
      head_pc_s   = ifu_fetch_pc;
    end else begin
      // hoff masks an already-consumed low halfword of the head entry
      if (cnt_r != 3'd0) begin
        head_hv_s = hv_r[rp_r] & {1'b1, ~hoff_r};
      end else begin
        head_hv_s = 2'b00;
      end
      if (cnt_r >= 3'd2) begin
        next_hv_s = hv_r[rp_nx_s];
      end else begin
        next_hv_s = 2'b00;
      end
    end
  end

  // Locate H0/H1, decide length, and work out which halfwords/entries an accept frees
  always_comb begin
    head_present_s = |head_hv_s;
    h0_hi_s        = ~head_hv_s[0];
    h0_s           = h0_hi_s ? head_data_s[31:16] : head_data_s[15:0];
    is32_s         = (h0_s[1:0] == 2'b11);
    h1_s           = 16'h0000;
    h1_present_s   = 1'b0;
    h1_in_next_s   = 1'b0;
    if (~h0_hi_s & head_hv_s[1]) begin
      h1_s         = head_data_s[31:16];
      h1_present_s = 1'b1;
    end else if (next_hv_s != 2'b00) begin
      // H1 lookup crosses into entry rp+1; rp_nx_s wraps 3 -> 0
      h1_s         = next_hv_s[0] ? next_data_s[15:0] : next_data_s[31:16];
      h1_present_s = 1'b1;
      h1_in_next_s = 1'b1;
    end else begin
      h1_s         = 16'h0000;
      h1_present_s = 1'b0;
      h1_in_next_s = 1'b0;
    end

    valid_s  = head_present_s & (~is32_s | h1_present_s) & ~exu_flush_final;
    accept_s = valid_s & dec_aln_ready;

    if (!accept_s) begin
      head_clr_s = 2'b00;
    end else if (h0_hi_s) begin
      head_clr_s = 2'b10;
    end else if (is32_s & ~h1_in_next_s) begin
      head_clr_s = 2'b11;
    end else begin
      head_clr_s = 2'b01;
    end

    if (accept_s & is32_s & h1_in_next_s) begin
      next_clr_s = next_hv_s[0] ? 2'b01 : 2'b10;
    end else begin
      next_clr_s = 2'b00;
    end

    head_rem_s  = head_hv_s & ~head_clr_s;
    next_rem_s  = next_hv_s & ~next_clr_s;
    // A bypassed group never occupied an entry, so it frees nothing
    head_free_s = accept_s & ~bypass_s & (head_rem_s == 2'b00);
    next_free_s = accept_s & ~bypass_s & (next_clr_s != 2'b00) & (next_rem_s == 2'b00);
    freed_s     = {1'b0, head_free_s} + {1'b0, next_free_s};
  end

  // Write qualification and offset of the next unread halfword at the new head
  always_comb begin
    wr_attempt_s = (ifu_fetch_val != 2'b00) & ~exu_flush_final;
    if (bypass_s) begin
      wr_hv_s = ifu_fetch_val & ~head_clr_s;
    end else begin
      wr_hv_s = ifu_fetch_val;
    end
    wr_en_s = wr_attempt_s & ~full_s & (wr_hv_s != 2'b00);

    if (!accept_s || bypass_s) begin
      hoff_nx_s = hoff_r;
    end else if (!head_free_s) begin
      hoff_nx_s = (head_rem_s == 2'b10);
    end else if ((next_clr_s != 2'b00) && !next_free_s) begin
      hoff_nx_s = (next_rem_s == 2'b10);
    end else begin
      hoff_nx_s = 1'b0;
    end
  end

  // Drive the alignment outputs; payload is zeroed whenever nothing is presented
  always_comb begin
    aln_valid       = valid_s;
    ifu_fb_consume1 = (freed_s == 2'd1);
    ifu_fb_consume2 = (freed_s == 2'd2);
    fb_overflow     = overflow_r;
    if (valid_s) begin
      aln_instr  = is32_s ? {h1_s, h0_s} : {16'h0000, h0_s};
      aln_pc     = head_pc_s + {30'd0, h0_hi_s};
      aln_is_16b = ~is32_s;
    end else begin
      aln_instr  = 32'h0000_0000;
      aln_pc     = 31'h0000_0000;
      aln_is_16b = 1'b0;
    end
  end

  // Buffer state: reset, flush, halfword consumption, writes, pointers and count
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= 32'h0000_0000;
        pc_r[i]   <= 31'h0000_0000;
        hv_r[i]   <= 2'b00;
      end
      wp_r       <= 2'd0;
      rp_r       <= 2'd0;
      cnt_r      <= 3'd0;
      hoff_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else if (exu_flush_final) begin
      for (int i = 0; i < DEPTH; i++) begin
        hv_r[i] <= 2'b00;
      end
      wp_r   <= 2'd0;
      rp_r   <= 2'd0;
      cnt_r  <= 3'd0;
      hoff_r <= 1'b0;
    end else begin
      if (accept_s && !bypass_s) begin
        hv_r[rp_r] <= hv_r[rp_r] & ~head_clr_s;
        if (next_clr_s != 2'b00) begin
          hv_r[rp_nx_s] <= hv_r[rp_nx_s] & ~next_clr_s;
        end
      end
      // wp never aliases a live entry being cleared: writes are refused when full
      if (wr_en_s) begin
        data_r[wp_r] <= ifu_fetch_data_f;
        pc_r[wp_r]   <= ifu_fetch_pc;
        hv_r[wp_r]   <= wr_hv_s;
        wp_r         <= wp_r + 2'd1;
      end
      rp_r   <= rp_r + freed_s;
      cnt_r  <= cnt_r - {1'b0, freed_s} + {2'b00, wr_en_s};
      hoff_r <= hoff_nx_s;
      if (wr_attempt_s && full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eb1_ifu_fetch_buf.sv
module tb_eb1_ifu_fetch_buf;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        exu_flush_final;
  logic [1:0]  ifu_fetch_val;
  logic [31:0] ifu_fetch_data_f;
  logic [30:0] ifu_fetch_pc;
  logic        dec_aln_ready;
  logic        aln_valid;
  logic [31:0] aln_instr;
  logic [30:0] aln_pc;
  logic        aln_is_16b;
  logic        ifu_fb_consume1;
  logic        ifu_fb_consume2;
  logic        fb_overflow;

  typedef struct packed {
    logic [31:0] instr;
    logic [30:0] pc;
    logic        is16;
    logic        c1;
    logic        c2;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  eb1_ifu_fetch_buf dut (
    .clk              (clk),
    .rst_l            (rst_l),
    .exu_flush_final  (exu_flush_final),
    .ifu_fetch_val    (ifu_fetch_val),
    .ifu_fetch_data_f (ifu_fetch_data_f),
    .ifu_fetch_pc     (ifu_fetch_pc),
    .dec_aln_ready    (dec_aln_ready),
    .aln_valid        (aln_valid),
    .aln_instr        (aln_instr),
    .aln_pc           (aln_pc),
    .aln_is_16b       (aln_is_16b),
    .ifu_fb_consume1  (ifu_fb_consume1),
    .ifu_fb_consume2  (ifu_fb_consume2),
    .fb_overflow      (fb_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [30:0] pc,
                      input logic is16, input logic c1, input logic c2);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.is16  = is16;
    e.c1    = c1;
    e.c2    = c2;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One write cycle, leaves inputs idle afterwards
  task automatic wr(input logic [1:0] val, input logic [31:0] data, input logic [30:0] pc);
    step();
    ifu_fetch_val    = val;
    ifu_fetch_data_f = data;
    ifu_fetch_pc     = pc;
    step();
    ifu_fetch_val    = 2'b00;
  endtask

  task automatic accept_n(input int n);
    step();
    dec_aln_ready = 1'b1;
    repeat (n) step();
    dec_aln_ready = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every accepted instruction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_l === 1'b1) begin
        if (aln_valid === 1'b1 && dec_aln_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_accept: got instr 0x%08h pc 0x%08h, required no instruction",
                     aln_instr, aln_pc);
          end else begin
            e = exp_q.pop_front();
            chk("aln_instr", aln_instr, e.instr);
            chk("aln_pc", aln_pc, e.pc);
            chk("aln_is_16b", aln_is_16b, e.is16);
            chk("consume1", ifu_fb_consume1, e.c1);
            chk("consume2", ifu_fb_consume2, e.c2);
          end
        end else begin
          chk("idle_consume", {ifu_fb_consume1, ifu_fb_consume2}, 2'b00);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_l            = 1'b0;
    exu_flush_final  = 1'b0;
    ifu_fetch_val    = 2'b00;
    ifu_fetch_data_f = 32'h0000_0000;
    ifu_fetch_pc     = 31'h0000_0000;
    dec_aln_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_l = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_aln_valid", aln_valid, 1'b0);
    chk("rst_aln_instr", aln_instr, 32'h0);
    chk("rst_aln_pc", aln_pc, 31'h0);
    chk("rst_is_16b", aln_is_16b, 1'b0);
    chk("rst_consume", {ifu_fb_consume1, ifu_fb_consume2}, 2'b00);
    chk("rst_overflow", fb_overflow, 1'b0);
    chk("rst_cnt", dut.cnt_r, 3'd0);

    // Single 32-bit instruction
    push(32'h00A0_0093, 31'h40, 1'b0, 1'b1, 1'b0);
    wr(2'b11, 32'h00A0_0093, 31'h40);
    @(negedge clk);
    chk("t1_cnt_after_write", dut.cnt_r, 3'd1);
    chk("t1_valid_after_write", aln_valid, 1'b1);
    accept_n(1);
    @(negedge clk);
    chk("t1_cnt_end", dut.cnt_r, 3'd0);

    // Two compressed instructions from one group
    push(32'h0000_4581, 31'h100, 1'b1, 1'b0, 1'b0);
    push(32'h0000_4501, 31'h101, 1'b1, 1'b1, 1'b0);
    wr(2'b11, 32'h4501_4581, 31'h100);
    accept_n(2);
    @(negedge clk);
    chk("t2_cnt_end", dut.cnt_r, 3'd0);

    // Straddling 32-bit instruction across entries
    push(32'h00A0_0093, 31'h201, 1'b0, 1'b0, 1'b1);
    wr(2'b10, 32'h0093_0000, 31'h200);
    @(negedge clk);
    chk("t3_h1_missing_valid", aln_valid, 1'b0);
    wr(2'b01, 32'h0000_00A0, 31'h202);
    @(negedge clk);
    chk("t3_cnt_two", dut.cnt_r, 3'd2);
    accept_n(1);
    @(negedge clk);
    chk("t3_cnt_end", dut.cnt_r, 3'd0);

    // Full and overflow
    for (int i = 0; i < 4; i++) begin
      push(32'h0000_0013 | (32'(i) << 16), 31'h300 + 31'(2 * i), 1'b0, 1'b1, 1'b0);
      wr(2'b11, 32'h0000_0013 | (32'(i) << 16), 31'h300 + 31'(2 * i));
    end
    @(negedge clk);
    chk("t4_cnt_full", dut.cnt_r, 3'd4);
    chk("t4_overflow_before", fb_overflow, 1'b0);
    wr(2'b11, 32'hDEAD_0013, 31'h380);
    @(negedge clk);
    chk("t4_cnt_after_drop", dut.cnt_r, 3'd4);
    chk("t4_overflow", fb_overflow, 1'b1);
    accept_n(4);
    @(negedge clk);
    chk("t4_cnt_end", dut.cnt_r, 3'd0);
    chk("t4_overflow_sticky", fb_overflow, 1'b1);

    // Flush at cnt=3 with a same-cycle write
    for (int i = 0; i < 3; i++) begin
      wr(2'b11, 32'h0000_0013 | (32'(i) << 20), 31'h400 + 31'(2 * i));
    end
    @(negedge clk);
    chk("t5_cnt_before", dut.cnt_r, 3'd3);
    step();
    exu_flush_final  = 1'b1;
    ifu_fetch_val    = 2'b11;
    ifu_fetch_data_f = 32'h1234_0013;
    ifu_fetch_pc     = 31'h480;
    dec_aln_ready    = 1'b1;
    @(negedge clk);
    chk("t5_flush_valid", aln_valid, 1'b0);
    chk("t5_flush_consume", {ifu_fb_consume1, ifu_fb_consume2}, 2'b00);
    step();
    exu_flush_final = 1'b0;
    ifu_fetch_val   = 2'b00;
    dec_aln_ready   = 1'b0;
    @(negedge clk);
    chk("t5_cnt_after", dut.cnt_r, 3'd0);
    chk("t5_valid_after", aln_valid, 1'b0);
    chk("t5_consume_after", {ifu_fb_consume1, ifu_fb_consume2}, 2'b00);
    chk("t5_overflow_kept", fb_overflow, 1'b1);

    // Wrap-around: 10 back-to-back 32-bit writes, accepted on arrival
    step();
    dec_aln_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
`ifdef RV_FB_BYPASS_EN
      push(32'h0000_0013 | (32'(i) << 16), 31'h500 + 31'(2 * i), 1'b0, 1'b0, 1'b0);
`else
      push(32'h0000_0013 | (32'(i) << 16), 31'h500 + 31'(2 * i), 1'b0, 1'b1, 1'b0);
`endif
      ifu_fetch_val    = 2'b11;
      ifu_fetch_data_f = 32'h0000_0013 | (32'(i) << 16);
      ifu_fetch_pc     = 31'h500 + 31'(2 * i);
      @(negedge clk);
      chk("t6_cnt_le1", {63'd0, (dut.cnt_r <= 3'd1)}, 64'd1);
`ifdef RV_FB_BYPASS_EN
      chk("t6_bypass_valid", aln_valid, 1'b1);
      chk("t6_bypass_pc", aln_pc, 31'h500 + 31'(2 * i));
`endif
      step();
    end
    ifu_fetch_val = 2'b00;
    repeat (2) step();
    dec_aln_ready = 1'b0;
    @(negedge clk);
    chk("t6_cnt_end", dut.cnt_r, 3'd0);

    // Reset mid-operation
    wr(2'b11, 32'h0000_0013, 31'h600);
    wr(2'b11, 32'h0001_0013, 31'h602);
    @(negedge clk);
    chk("t7_cnt_before", dut.cnt_r, 3'd2);
    step();
    rst_l = 1'b0;
    step();
    rst_l = 1'b1;
    @(negedge clk);
    chk("t7_cnt_after", dut.cnt_r, 3'd0);
    chk("t7_valid_after", aln_valid, 1'b0);
    chk("t7_overflow_after", fb_overflow, 1'b0);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
